pipe_reg_skid: RTL and testbench

PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

---
 rtl/pipe_reg_skid_pkg.sv | 10 +
 rtl/pipe_reg_skid.sv | 83 ++++++++
 tb/tb_pipe_reg_skid.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_skid_pkg.sv
// Shared data-path types for the two-entry skid pipeline register.
package pipe_reg_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_reg_skid.sv
// Two-entry pipeline register with skid slot; handshake outputs come from state only.
//
//   state | meaning
//   EMPTY | no entries held, out_valid=0
//   ONE   | head entry in main, skid unused
//   TWO   | main and skid both full, in_ready=0
module pipe_reg_skid
    import pipe_reg_skid_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  stall_cnt
);

    skid_state_t      state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [CNTW-1:0]  stall_q;
    logic             accept;
    logic             emit;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign stall_cnt = stall_q;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            // Saturating stall counter; flush deliberately leaves it alone.
            if (out_valid && !out_ready && (stall_q != {CNTW{1'b1}}))
                stall_q <= stall_q + 1'b1;

            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_q <= in_data;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && emit) begin
                            main_q <= in_data;
                        end else if (accept) begin
                            skid_q <= in_data;
                            state  <= TWO;
                        end else if (emit) begin
                            state  <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (emit) begin
                            main_q <= skid_q;
                            state  <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid: queue-based reference model plus literal checkpoints.
module tb_pipe_reg_skid;

    localparam int WIDTH = 32;
    localparam int CNTW  = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNTW-1:0]  stall_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [WIDTH-1:0] mq[$];
    int               m_stall = 0;

    pipe_reg_skid #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries.
    always @(posedge CLK) begin
        if (RST) begin
            mq.delete();
            m_stall = 0;
        end else begin
            bit m_emit;
            bit m_acc;
            m_emit = (mq.size() > 0) && out_ready;
            m_acc  = in_valid && (mq.size() < 2);
            if ((mq.size() > 0) && !out_ready && (m_stall < (1 << CNTW) - 1))
                m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_emit) void'(mq.pop_front());
                if (m_acc)  mq.push_back(in_data);
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
            check("model_in_ready",  {31'b0, in_ready},  {31'b0, mq.size() < 2});
            check("model_stall_cnt", {28'b0, stall_cnt}, m_stall);
            if (mq.size() > 0)
                check("model_out_data", out_data, mq[0]);
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic ordy,
                         input logic fl, input logic rst);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        RST       = rst;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 1);
        tick();
        tick();
        chk_en = 1'b1;
        drive(0, 0, 0, 0, 0);
        check("reset_out_valid", {31'b0, out_valid}, 0);
        check("reset_in_ready",  {31'b0, in_ready},  1);
        check("reset_stall",     {28'b0, stall_cnt}, 0);

        // pass-through
        drive(1, 32'hA5A5A5A5, 1, 0, 0);
        tick();
        check("pass_out_valid", {31'b0, out_valid}, 1);
        check("pass_out_data",  out_data, 32'hA5A5A5A5);
        drive(0, 0, 1, 0, 0);
        tick();
        check("pass_empty", {31'b0, out_valid}, 0);

        // skid fill then drain in order
        drive(1, 32'h11, 0, 0, 0);
        tick();
        drive(1, 32'h22, 0, 0, 0);
        tick();
        check("skid_in_ready", {31'b0, in_ready}, 0);
        check("skid_head",     out_data, 32'h11);
        check("skid_stall",    {28'b0, stall_cnt}, 1);
        drive(0, 0, 1, 0, 0);
        tick();
        check("drain_second",   out_data, 32'h22);
        check("drain_in_ready", {31'b0, in_ready}, 1);
        tick();
        check("drain_empty", {31'b0, out_valid}, 0);

        // flush in TWO drops a same-cycle push
        drive(1, 32'h44, 0, 0, 0);
        tick();
        drive(1, 32'h55, 0, 0, 0);
        tick();
        drive(1, 32'h33, 0, 1, 0);
        tick();
        check("flush_out_valid", {31'b0, out_valid}, 0);
        check("flush_in_ready",  {31'b0, in_ready}, 1);
        check("flush_stall",     {28'b0, stall_cnt}, 3);
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_33", {31'b0, out_valid}, 0);
        end

        // stall counter saturation
        drive(1, 32'h66, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall", {28'b0, stall_cnt}, 15);
        tick();
        check("sat_hold",  {28'b0, stall_cnt}, 15);
        check("sat_head",  out_data, 32'h66);

        // reset beats flush while in TWO
        drive(1, 32'h77, 0, 0, 0);
        tick();
        check("pre_rst_full", {31'b0, in_ready}, 0);
        drive(1, 32'h88, 1, 1, 1);
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_in_ready",  {31'b0, in_ready}, 1);
        check("rst_stall",     {28'b0, stall_cnt}, 0);

        // continuous streaming
        for (int k = 1; k <= 8; k++) begin
            drive(1, k, 1, 0, 0);
            tick();
            check("stream_data",     out_data, k);
            check("stream_valid",    {31'b0, out_valid}, 1);
            check("stream_in_ready", {31'b0, in_ready}, 1);
        end
        drive(0, 0, 1, 0, 0);
        tick();
        check("stream_end", {31'b0, out_valid}, 0);
        check("stream_no_stall", {28'b0, stall_cnt}, 0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
